// File: rtl/status_flag_unit_if.sv
// Bus between the LEGv8 control unit and the status/flag unit: control word and
// ALU flags going in, status vector and sequence monitoring coming back.
interface status_flag_unit_if #(
  parameter int CW_LENGTH = 40,
  parameter int RETIRE_W  = 32
);
  logic [CW_LENGTH-1:0] ControlWord;
  logic                 alu_v;
  logic                 alu_c;
  logic                 alu_n;
  logic                 alu_z;
  logic [63:0]          b_bus;
  logic [4:0]           status;
  logic [2:0]           cur_state;
  logic [RETIRE_W-1:0]  retired;
  logic                 fault;
  logic [1:0]           fault_code;

  modport master (
    output ControlWord, alu_v, alu_c, alu_n, alu_z, b_bus,
    input  status, cur_state, retired, fault, fault_code
  );

  modport slave (
    input  ControlWord, alu_v, alu_c, alu_n, alu_z, b_bus,
    output status, cur_state, retired, fault, fault_code
  );
endinterface

// File: rtl/status_flag_unit.sv
// Status register, microstate tracker, retire counter and EX watchdog that sit
// beside the LEGv8 control unit and flag illegal or stalled sequences.
module status_flag_unit #(
  parameter int CW_LENGTH     = 40,
  parameter int MAX_EX_CYCLES = 6,
  parameter int RETIRE_W      = 32
) (
  input  logic               clock,
  input  logic               reset,
  status_flag_unit_if.slave  bus
);

  localparam int EXW = $clog2(MAX_EX_CYCLES + 2);
  localparam logic [EXW-1:0] EX_LIMIT = EXW'(MAX_EX_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_EX0 = 3'd1,
    ST_EX1 = 3'd2,
    ST_EX2 = 3'd3,
    ST_EX3 = 3'd4,
    ST_EX4 = 3'd5,
    ST_EX5 = 3'd6,
    ST_BAD = 3'd7
  } state_e;

  logic [CW_LENGTH-1:0] cw_s;
  logic [2:0]           ns_s;
  logic                 sl_s;
  logic                 zl_s;
  logic                 illegal_s;
  logic                 expire_s;

  logic [4:0]           status_q,  status_d;
  state_e               state_q,   state_d;
  logic [RETIRE_W-1:0]  retired_q, retired_d;
  logic                 fault_q,   fault_d;
  logic [1:0]           code_q,    code_d;
  logic [EXW-1:0]       ex_q,      ex_d;

  assign cw_s = bus.ControlWord;
  assign ns_s = cw_s[36:34];
  assign sl_s = cw_s[15];
  assign zl_s = cw_s[16];

  // State register; reset beats everything, including a fault being raised.
  always_ff @(posedge clock) begin
    if (reset) begin
      status_q  <= 5'd0;
      state_q   <= ST_IF;
      retired_q <= '0;
      fault_q   <= 1'b0;
      code_q    <= 2'b00;
      ex_q      <= '0;
    end else begin
      status_q  <= status_d;
      state_q   <= state_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
      ex_q      <= ex_d;
    end
  end

  // Next-state logic for flags, microstate, retire count, watchdog and fault.
  always_comb begin
    status_d  = status_q;
    state_d   = state_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    code_d    = code_q;
    ex_d      = ex_q;
    illegal_s = 1'b0;
    expire_s  = 1'b0;

    if (sl_s) begin
      status_d[3:0] = {bus.alu_v, bus.alu_c, bus.alu_n, bus.alu_z};
    end else begin
      status_d[3:0] = status_q[3:0];
    end

    if (zl_s) begin
      status_d[4] = (bus.b_bus == 64'd0);
    end else begin
      status_d[4] = status_q[4];
    end

    // Watchdog saturates at the limit, so a stalled instruction stays parked
    // in IF until the control unit finally returns to IF itself.
    if (ns_s == 3'd0) begin
      ex_d = '0;
    end else if (ex_q == EX_LIMIT) begin
      ex_d = EX_LIMIT;
    end else begin
      ex_d = ex_q + {{(EXW-1){1'b0}}, 1'b1};
    end

    illegal_s = (ns_s == 3'd7);
    expire_s  = (ns_s != 3'd0) && (ex_d == EX_LIMIT);

    case (state_e'(ns_s))
      ST_BAD:  state_d = ST_IF;
      default: state_d = expire_s ? ST_IF : state_e'(ns_s);
    endcase

    if ((state_q != ST_IF) && (ns_s == 3'd0)) begin
      retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end else begin
      retired_d = retired_q;
    end

    // Only the first fault is recorded; illegal NS outranks a timeout.
    if (illegal_s || expire_s) begin
      fault_d = 1'b1;
      if (!fault_q) begin
        code_d = illegal_s ? 2'b01 : 2'b10;
      end else begin
        code_d = code_q;
      end
    end else begin
      fault_d = fault_q;
      code_d  = code_q;
    end
  end

  assign bus.status     = status_q;
  assign bus.cur_state  = state_q;
  assign bus.retired    = retired_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;

endmodule

// File: doc/status_flag_unit.md
Name: status_flag_unit

Overview:
- Datapath-side partner of the LEGv8 control unit. Consumes the 40-bit control word the control unit issues each cycle and the raw ALU flags.
- Produces the registered 5-bit status vector that the control unit uses for branch decisions.
- Tracks the control unit's current microstate, counts retired instructions, and raises a sticky fault on an illegal or stalled sequence.

Parameters:
- CW_LENGTH, 40, control word width; the field map below is fixed for 40.
- MAX_EX_CYCLES, 6, maximum consecutive non-IF cycles allowed per instruction.
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- ControlWord  input  CW_LENGTH  control word currently issued by the control unit.
- alu_v, alu_c, alu_n, alu_z  input  1 each  raw ALU overflow, carry, negative and zero flags.
- b_bus  input  64  register-file B read data, used for the CBZ/CBNZ zero test.
- status  output  5  {zero_b, V, C, N, Z}, registered; feeds the control unit's status input.
- cur_state  output  3  microstate the control unit is in this cycle (0 = IF, 1..6 = EX0..EX5).
- retired  output  RETIRE_W  count of completed instructions.
- fault  output  1  sticky sequence error.
- fault_code  output  2  01 = illegal next-state 7, 10 = EX timeout, 00 = none.

Behaviour:
Field map (decided):
- ControlWord[36:34] = next state NS.
- ControlWord[15] = SL (status load).
- ControlWord[16] = ZL (zero-detect load).
- All other bits are ignored by this block.

Reset (reset = 1 at a clock edge):
- status = 0, cur_state = 0, retired = 0, fault = 0, fault_code = 00, internal ex_count = 0.
- Reset takes priority over every other event, including a fault in progress.

Status register:
- Edge with SL = 1: status[3:0] <= {alu_v, alu_c, alu_n, alu_z}.
- Edge with ZL = 1: status[4] <= (b_bus == 0).
- SL and ZL are independent; both may be set in the same cycle.
- With neither set, status holds.
- Latency is one cycle: flags from cycle t are visible on status in cycle t+1.

State tracker:
- Each edge: cur_state <= NS, except when NS = 7.
- NS = 7: cur_state <= 0, fault <= 1, fault_code <= 01 if fault was 0.

Retire counter:
- Increments when cur_state != 0 and the accepted NS = 0 (return to IF).
- Wraps modulo 2^RETIRE_W.
- Does not increment on the NS = 7 recovery.

EX watchdog:
- ex_count <= 0 when the accepted NS = 0; otherwise ex_count <= ex_count + 1, saturating.
- On the edge where ex_count would reach MAX_EX_CYCLES + 1: fault <= 1, fault_code <= 10 if fault was 0, and cur_state is forced to 0.

Fault handling:
- fault is sticky and cleared only by reset.
- fault_code records only the first fault.
- After a fault, the status, retire and state logic keep operating normally.

Simultaneous events:
- Illegal NS and watchdog expiry on the same edge: fault_code = 01.
- SL together with NS = 0: the flag latch and the retire increment both occur.

Test Plan:
- Reset held for 2 cycles with random ControlWord → status = 0, cur_state = 0, retired = 0, fault = 0.
- SL = 1 with alu flags V,C,N,Z = 1,0,1,0, then SL = 0 with flags inverted → status[3:0] = 1010 on the cycle after SL and held thereafter.
- ZL = 1 with b_bus = 0, then ZL = 1 with b_bus = 5 → status[4] = 1, then 0, each one cycle later; status[3:0] unchanged.
- NS sequence 1,2,0,1,0 → cur_state follows 1,2,0,1,0 and retired = 2.
- NS = 1 for 8 consecutive cycles → fault = 1, fault_code = 10 after the 7th non-IF cycle, cur_state = 0; assert reset → fault clears.
- NS = 7 in one cycle, then NS = 7 again → fault_code stays 01, cur_state = 0, retired unchanged.
